// File: rtl/generic_bus_sram_sub.sv
// Generic-bus subordinate backed by a Depth x DataWidth byte-strobed SRAM with a fixed wait-state count.
// Optional address/illegal-transfer error reporting is enabled by defining GENERIC_BUS_SRAM_SUB_ERR_EN.
module generic_bus_sram_sub #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int Depth      = 16,
  parameter int WaitStates = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AddrWidth-1:0]   addr,
  input  logic                   wEn,
  input  logic                   rEn,
  input  logic [DataWidth-1:0]   wData,
  input  logic [DataWidth/8-1:0] wStrb,
  output logic [DataWidth-1:0]   rData,
  output logic                   busy,
  output logic                   error
);

  localparam int Bytes   = DataWidth / 8;
  localparam int ByteOff = $clog2(Bytes);
  localparam int IdxW    = $clog2(Depth);
  localparam logic [3:0] WsCnt = 4'(WaitStates);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_nxt;
  logic [DataWidth-1:0] r_mem [Depth];

  logic            w_req;
  logic            w_both;
  logic            w_busy_raw;
  logic            w_done_raw;
  logic            w_done;
  logic            w_bad;
  logic            w_wr;
  logic            w_rd;
  logic [IdxW-1:0] w_idx;
  logic            w_unused;

  assign w_req  = wEn | rEn;
  assign w_both = wEn & rEn;
  assign w_idx  = addr[ByteOff +: IdxW];
  // Upper and sub-word address bits only matter when error checking is built in.
  assign w_unused = ^addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_req && (WsCnt != 4'd0)) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = 4'd1;
        end
      end
      ST_WAIT: begin
        // A dropped request abandons the transfer just like a normal completion.
        if (!w_req || (r_cnt >= WsCnt)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    w_busy_raw = 1'b0;
    w_done_raw = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (WsCnt == 4'd0) w_done_raw = 1'b1;
          else               w_busy_raw = 1'b1;
        end
      end
      ST_WAIT: begin
        if (w_req) begin
          if (r_cnt >= WsCnt) w_done_raw = 1'b1;
          else                w_busy_raw = 1'b1;
        end
      end
      default: begin
        w_busy_raw = 1'b0;
        w_done_raw = 1'b0;
      end
    endcase
  end

  assign busy   = w_busy_raw & ~reset;
  assign w_done = w_done_raw & ~reset;

`ifdef GENERIC_BUS_SRAM_SUB_ERR_EN
  localparam logic [AddrWidth:0]   AddrLimit = (AddrWidth+1)'(Depth * Bytes);
  localparam logic [AddrWidth-1:0] AlignMask = AddrWidth'(Bytes - 1);

  logic w_addr_err;
  assign w_addr_err = ((addr & AlignMask) != '0) || ({1'b0, addr} >= AddrLimit);
  assign w_bad      = w_addr_err | w_both;
  assign error      = w_done & w_bad;
`else
  assign w_bad = w_both;
  assign error = 1'b0;
`endif

  assign w_wr  = w_done & wEn & ~w_bad;
  assign w_rd  = w_done & rEn & ~w_bad;
  assign rData = w_rd ? r_mem[w_idx] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      for (int b = 0; b < Bytes; b++) begin
        if (wStrb[b]) r_mem[w_idx][b*8 +: 8] <= wData[b*8 +: 8];
      end
    end
  end

endmodule
